// File: rtl/sprite_buffer_loader.sv
// Packs a raster-ordered 1-bit RGB pixel stream into three BUF_BITS-wide sprite bitmaps.
// Optional build macro SPRITE_LOADER_MIRROR_EN stores each row horizontally mirrored.
module sprite_buffer_loader #(
    parameter int BUF_BITS = 255,
    parameter int DIM_W    = 10
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_W-1:0]     largura,
    input  logic [DIM_W-1:0]     altura,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 pix_r,
    input  logic                 pix_g,
    input  logic                 pix_b,
    output logic [0:BUF_BITS-1]  BUFFER_R,
    output logic [0:BUF_BITS-1]  BUFFER_G,
    output logic [0:BUF_BITS-1]  BUFFER_B,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int PW = 2 * DIM_W;
    localparam int IW = $clog2(BUF_BITS);
    localparam logic [PW-1:0] CAP = PW'(BUF_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [0:BUF_BITS-1] buf_r_q, buf_r_d;
    logic [0:BUF_BITS-1] buf_g_q, buf_g_d;
    logic [0:BUF_BITS-1] buf_b_q, buf_b_d;
    logic [DIM_W-1:0]    lar_q, lar_d;
    logic [DIM_W-1:0]    x_q, x_d;
    logic [DIM_W-1:0]    y_q, y_d;
    logic [PW-1:0]       total_q, total_d;
    logic [PW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       row_q, row_d;
    logic                err_q, err_d;

    logic [PW-1:0]       total_req;
    logic [PW-1:0]       wr_idx;
    logic [IW-1:0]       wr_bit;
    logic                xfer;

    always_comb begin
        state_d = state_q;
        buf_r_d = buf_r_q;
        buf_g_d = buf_g_q;
        buf_b_d = buf_b_q;
        lar_d   = lar_q;
        x_d     = x_q;
        y_d     = y_q;
        total_d = total_q;
        idx_d   = idx_q;
        row_d   = row_q;
        err_d   = err_q;

        pix_ready = (state_q == S_LOAD);
        busy      = (state_q == S_LOAD);
        done      = (state_q == S_DONE);
        xfer      = pix_ready && pix_valid;

        // Full-width product so oversize requests can never alias into range.
        total_req = {{DIM_W{1'b0}}, largura} * {{DIM_W{1'b0}}, altura};

`ifdef SPRITE_LOADER_MIRROR_EN
        wr_idx = row_q + {{DIM_W{1'b0}}, lar_q - DIM_W'(1) - x_q};
`else
        wr_idx = idx_q;
`endif
        wr_bit = wr_idx[IW-1:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (total_req == '0) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                        buf_r_d = '0;
                        buf_g_d = '0;
                        buf_b_d = '0;
                    end else if (total_req > CAP) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        err_d   = 1'b0;
                        lar_d   = largura;
                        total_d = total_req;
                        x_d     = '0;
                        y_d     = '0;
                        idx_d   = '0;
                        row_d   = '0;
                        buf_r_d = '0;
                        buf_g_d = '0;
                        buf_b_d = '0;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (wr_idx < total_q) begin
                        buf_r_d[wr_bit] = pix_r;
                        buf_g_d[wr_bit] = pix_g;
                        buf_b_d[wr_bit] = pix_b;
                    end
                    idx_d = idx_q + PW'(1);
                    if (x_q == lar_q - DIM_W'(1)) begin
                        x_d   = '0;
                        y_d   = y_q + DIM_W'(1);
                        row_d = row_q + {{DIM_W{1'b0}}, lar_q};
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                    if (idx_q == total_q - PW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_r_q <= '0;
            buf_g_q <= '0;
            buf_b_q <= '0;
            lar_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            total_q <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_r_q <= buf_r_d;
            buf_g_q <= buf_g_d;
            buf_b_q <= buf_b_d;
            lar_q   <= lar_d;
            x_q     <= x_d;
            y_q     <= y_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    assign BUFFER_R = buf_r_q;
    assign BUFFER_G = buf_g_q;
    assign BUFFER_B = buf_b_q;
    assign err      = err_q;

endmodule

// File: doc/sprite_buffer_loader.md
Name: sprite_buffer_loader

Overview:
- Fills the packed 1-bit-per-channel sprite bitmaps (R, G, B vectors, 255 bits each) that the VGA sprite renderer consumes.
- Accepts a raster-ordered pixel stream (x fastest, then y) over a valid/ready handshake, after a start command that carries sprite width/height.
- Packs each accepted pixel into bit index y*width + x and reports completion.
- Sits between the sprite ROM/stream source and the renderer's BUFFER_R/G/B inputs.

Parameters:
- BUF_BITS, 255, capacity of each channel vector in pixels.
- DIM_W, 10, width of the dimension and coordinate fields.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle load command; sampled only in IDLE.
- largura  input  DIM_W  sprite width in pixels; sampled on accepted start.
- altura  input  DIM_W  sprite height in pixels; sampled on accepted start.
- pix_valid  input  1  source has a pixel on pix_r/g/b.
- pix_ready  output  1  loader accepts the pixel this cycle.
- pix_r, pix_g, pix_b  input  1 each  pixel colour bits.
- BUFFER_R, BUFFER_G, BUFFER_B  output  [0:BUF_BITS-1] each  packed bitmaps; bit index 0 is pixel (0,0).
- busy  output  1  high while in LOAD.
- done  output  1  one-cycle pulse when the last pixel has been written.
- err  output  1  sticky: last start was rejected.

Behaviour:
- Reset is synchronous, active-high, on clock CLK. On reset: state=IDLE; all BUFFER_* bits 0; pix_ready=0; busy=0; done=0; err=0; counters 0. Reset mid-LOAD aborts immediately, with the same values.
- States: IDLE, LOAD, DONE.
- IDLE:
  - pix_ready=0.
  - On start, compute total = largura*altura at full width (2*DIM_W bits; no truncation).
  - total==0: go to DONE, err=0, buffers cleared.
  - total>BUF_BITS: stay in IDLE, err=1, buffers unchanged.
  - Otherwise: latch dims and total; clear all three buffers to 0; x=y=idx=0; err=0; go to LOAD.
- LOAD:
  - pix_ready=1 combinationally; busy=1. Transfer happens when pix_valid && pix_ready.
  - On a transfer: BUFFER_R[idx]<=pix_r, BUFFER_G[idx]<=pix_g, BUFFER_B[idx]<=pix_b. The write is visible on the outputs the cycle after the transfer.
  - Counter update: x increments; at x==largura-1, x wraps to 0 and y increments. idx = y*largura + x, maintained incrementally (+1 per transfer).
  - Transfer with idx==total-1: go to DONE.
  - pix_valid low: no change (stall, arbitrary length).
  - start during LOAD is ignored.
- DONE:
  - done=1 for exactly one cycle; pix_ready=0; busy=0.
  - Next state is IDLE unconditionally.
  - A start arriving in the DONE cycle is ignored.
- Latency: first pixel accepted the cycle after start. Back-to-back valid gives 1 pixel/cycle. done asserts the cycle after the last transfer.
- Buffers hold their contents until the next accepted start or reset. Bits at index >= total stay 0.
- Bits are never written outside [0, total-1]; idx never exceeds BUF_BITS-1.

Optional Feature:
- Macro: SPRITE_LOADER_MIRROR_EN.
- Defined: horizontal mirror; pixel (x,y) is written to index y*largura + (largura-1-x). Counters, handshake and done timing are unchanged.
- Undefined: straight raster, index y*largura + x.

Test Plan:
- Reset: apply reset 2 cycles -> all BUFFER_* zero, busy=0, done=0, err=0, pix_ready=0.
- 4x3 load: largura=4, altura=3, start, then 12 back-to-back pixels with pix_r=1 only at pixel 5 (x=1,y=1) -> BUFFER_R[5]=1, all other bits 0; done pulses exactly once, 13 cycles after start; busy high for 12 cycles.
- Stalls: 2x2 load with pix_valid toggling 1,0,0,1,1,0,1 -> exactly 4 transfers; done the cycle after the 4th; buffers match the data sent.
- Rejects: largura=16, altura=16 (256>255) -> err=1, stays IDLE, previous buffer contents intact. largura=0 -> done pulse next cycle, err=0, buffers zero.
- Boundaries: 15x17=255 full load with all-ones data -> every bit of BUFFER_G is 1, done pulses. Reset asserted after 100 pixels -> buffers zero, IDLE.
- Mirror (SPRITE_LOADER_MIRROR_EN defined): 4x1 stream R=1,0,0,0 -> BUFFER_R[3]=1, BUFFER_R[0]=0.
